// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default framing constants
// common to the transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      ERR
   } uart_state_t;

   localparam int DEFAULT_CLOCKS_PER_PULSE = 4;
   localparam int DEFAULT_BITS_PER_WORD    = 8;
   localparam int DEFAULT_W_OUT            = 24;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx_in,
   output logic rx_out
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b1;
         rx_out <= 1'b1;
      end else begin
         meta   <= rx_in;
         rx_out <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver assembling NUM_WORDS frames into one packet with a valid/ready
// output. Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of rx.
module uart_rx
   import uart_pkg::*;
#(
   parameter  int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
   parameter  int BITS_PER_WORD    = DEFAULT_BITS_PER_WORD,
   parameter  int W_OUT            = DEFAULT_W_OUT,
   localparam int NUM_WORDS        = W_OUT / BITS_PER_WORD
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     rx,
   output logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0]  m_data,
   output logic                                     m_valid,
   input  logic                                     m_ready,
   output logic                                     m_error,
   output logic                                     m_overflow
);

   localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
   localparam int BW = $clog2(BITS_PER_WORD + 1);
   localparam int WW = $clog2(NUM_WORDS + 1);

   localparam logic [CW-1:0] HALF_CNT  = CW'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(CLOCKS_PER_PULSE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

   if (W_OUT % BITS_PER_WORD != 0) begin : g_bad_width
      $error("uart_rx: W_OUT must be a multiple of BITS_PER_WORD");
   end

   uart_state_t                             state, next_state;
   logic                                    rx_s;
   logic [CW-1:0]                           clk_cnt;
   logic [BW-1:0]                           bit_cnt;
   logic [WW-1:0]                           word_cnt;
   logic [BITS_PER_WORD-1:0]                shift_reg;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] asm_reg;
   logic [NUM_WORDS-1:0][BITS_PER_WORD-1:0] full_packet;
   logic                                    half_tick, full_tick;
   logic                                    cnt_run, shift_en, word_done, frame_err, pkt_done;

`ifdef UART_RX_SYNC_EN
   uart_rx_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .rx_in  (rx),
      .rx_out (rx_s)
   );
`else
   assign rx_s = rx;
`endif

   assign half_tick = (clk_cnt == HALF_CNT);
   assign full_tick = (clk_cnt == FULL_CNT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // START checks mid start-bit to reject glitches; DATA/STOP sample mid-bit.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!rx_s) next_state = START;
         START:   if (half_tick) next_state = rx_s ? IDLE : DATA;
         DATA:    if (full_tick && bit_cnt == LAST_BIT) next_state = STOP;
         STOP:    if (full_tick) next_state = rx_s ? IDLE : ERR;
         ERR:     if (rx_s) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cnt_run   = 1'b0;
      shift_en  = 1'b0;
      word_done = 1'b0;
      frame_err = 1'b0;
      case (state)
         START: cnt_run = 1'b1;
         DATA: begin
            cnt_run  = 1'b1;
            shift_en = full_tick;
         end
         STOP: begin
            cnt_run   = 1'b1;
            word_done = full_tick && rx_s;
            frame_err = full_tick && !rx_s;
         end
         default: ;
      endcase
   end

   assign pkt_done = word_done && (word_cnt == LAST_WORD);

   always_ff @(posedge clk) begin
      if (rst || !cnt_run || next_state != state || full_tick) clk_cnt <= '0;
      else                                                    clk_cnt <= clk_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || state != DATA) bit_cnt <= '0;
      else if (shift_en)        bit_cnt <= bit_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)           shift_reg <= '0;
      else if (shift_en) shift_reg <= {rx_s, shift_reg[BITS_PER_WORD-1:1]};
   end

   // A framing error throws away any words already gathered for this packet.
   always_ff @(posedge clk) begin
      if (rst || frame_err) begin
         word_cnt <= '0;
         asm_reg  <= '0;
      end else if (word_done) begin
         asm_reg[word_cnt] <= shift_reg;
         word_cnt          <= pkt_done ? '0 : word_cnt + 1'b1;
      end
   end

   always_comb begin
      full_packet           = asm_reg;
      full_packet[word_cnt] = shift_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_data     <= '0;
         m_valid    <= 1'b0;
         m_error    <= 1'b0;
         m_overflow <= 1'b0;
      end else begin
         m_error    <= frame_err;
         m_overflow <= 1'b0;
         if (pkt_done && (!m_valid || m_ready)) begin
            m_data  <= full_packet;
            m_valid <= 1'b1;
         end else if (pkt_done) begin
            m_overflow <= 1'b1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serialiser task plays the transmitter and a
// negedge monitor pops expected packets on every m_valid && m_ready transfer.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CPP  = 4;
   localparam int BPW  = 8;
   localparam int WOUT = 24;
   localparam int NW   = WOUT / BPW;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    rx;
   logic [NW-1:0][BPW-1:0]  m_data;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_error;
   logic                    m_overflow;

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   int ovf_cnt = 0;
   int xfer_cnt = 0;
   int spurious_cnt = 0;
   logic [WOUT-1:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx #(
      .CLOCKS_PER_PULSE (CPP),
      .BITS_PER_WORD    (BPW),
      .W_OUT            (WOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_error    (m_error),
      .m_overflow (m_overflow)
   );

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendBit(input logic b);
      rx = b;
      tick(CPP);
   endtask

   task automatic sendFrame(input logic [BPW-1:0] word, input int nstop);
      sendBit(1'b0);
      for (int i = 0; i < BPW; i++) sendBit(word[i]);
      repeat (nstop) sendBit(1'b1);
   endtask

   // Words go out lowest first; push only when the packet should be delivered.
   task automatic applyStimulus(input logic [WOUT-1:0] pkt, input int nstop, input bit expect_out);
      if (expect_out) exp_q.push_back(pkt);
      for (int w = 0; w < NW; w++) sendFrame(pkt[w*BPW +: BPW], nstop);
   endtask

   task automatic waitDrain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick(1);
         n++;
      end
      checkOutput(tag, 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m_error) err_cnt++;
         if (m_overflow) ovf_cnt++;
         if (m_valid && m_ready) begin
            xfer_cnt++;
            if (exp_q.size() > 0) checkOutput("packet", 64'(m_data), 64'(exp_q.pop_front()));
            else spurious_cnt++;
         end
      end
   end

   initial begin
      int e0, x0, o0;
      logic [WOUT-1:0] p1, p2, pkt;

      rst = 1'b1;
      rx = 1'b1;
      m_ready = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      checkOutput("reset_valid", 64'(m_valid), 64'd0);
      checkOutput("reset_data", 64'(m_data), 64'd0);
      checkOutput("reset_error", 64'(m_error), 64'd0);
      checkOutput("reset_overflow", 64'(m_overflow), 64'd0);
      checkOutput("reset_state", 64'(dut.state), 64'(IDLE));

      $display("[TB] basic packet A5 3C 0F");
      e0 = err_cnt; x0 = xfer_cnt;
      applyStimulus(24'h0F3CA5, 4, 1'b1);
      waitDrain("basic_drain");
      checkOutput("basic_xfers", 64'(xfer_cnt - x0), 64'd1);
      checkOutput("basic_errors", 64'(err_cnt - e0), 64'd0);

      $display("[TB] backpressure with overflow");
      m_ready = 1'b0;
      p1 = 24'h123456;
      p2 = 24'hABCDEF;
      x0 = xfer_cnt; o0 = ovf_cnt;
      applyStimulus(p1, 4, 1'b1);
      applyStimulus(p2, 4, 1'b0);
      checkOutput("hold_valid", 64'(m_valid), 64'd1);
      checkOutput("hold_data", 64'(m_data), 64'(p1));
      checkOutput("hold_overflow", 64'(ovf_cnt - o0), 64'd1);
      checkOutput("hold_no_xfer", 64'(xfer_cnt - x0), 64'd0);
      m_ready = 1'b1;
      tick(4);
      checkOutput("release_xfers", 64'(xfer_cnt - x0), 64'd1);
      waitDrain("release_drain");

      $display("[TB] one-cycle glitch");
      e0 = err_cnt; x0 = xfer_cnt;
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(10);
      checkOutput("glitch_state", 64'(dut.state), 64'(IDLE));
      checkOutput("glitch_errors", 64'(err_cnt - e0), 64'd0);
      checkOutput("glitch_xfers", 64'(xfer_cnt - x0), 64'd0);

      $display("[TB] framing error then recovery");
      e0 = err_cnt;
      sendFrame(8'h77, 1);
      sendBit(1'b0);
      for (int i = 0; i < BPW; i++) sendBit(1'(i % 2));
      rx = 1'b0;
      tick(10);
      rx = 1'b1;
      tick(CPP);
      checkOutput("ferr_pulses", 64'(err_cnt - e0), 64'd1);
      applyStimulus(24'hC3B2A1, 2, 1'b1);
      waitDrain("ferr_drain");
      checkOutput("ferr_pulses_after", 64'(err_cnt - e0), 64'd1);

      $display("[TB] reset mid-frame");
      e0 = err_cnt;
      sendFrame(8'h5A, 1);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      rst = 1'b1;
      rx = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      checkOutput("rst_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_data", 64'(m_data), 64'd0);
      checkOutput("rst_error", 64'(m_error), 64'd0);
      applyStimulus(24'h9E8D7C, 1, 1'b1);
      waitDrain("rst_drain");
      checkOutput("rst_no_error", 64'(err_cnt - e0), 64'd0);

      $display("[TB] random loopback packets");
      e0 = err_cnt; x0 = xfer_cnt;
      for (int k = 0; k < 100; k++) begin
         pkt = 24'($urandom());
         applyStimulus(pkt, $urandom_range(1, 3), 1'b1);
      end
      waitDrain("rand_drain");
      checkOutput("rand_xfers", 64'(xfer_cnt - x0), 64'd100);
      checkOutput("rand_errors", 64'(err_cnt - e0), 64'd0);
      checkOutput("spurious_xfers", 64'(spurious_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
